// File: rtl/mul_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: default width, FSM encoding
// and the iteration counter width.
package mul_hilo_unit_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ADD,
    ST_SHIFT,
    ST_FIX
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_hilo_unit_dp.sv
// Shift-add multiplier datapath: multiplicand, (2W+1)-bit accumulator and
// iteration counter, sequenced by Load/Ad/Sh from the controlling FSM.
module mul_shift_add_dp
  import mul_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic                 Ad,
  input  logic                 Sh,
  input  logic                 Neg,
  input  logic [WIDTH-1:0]     McandIn,
  input  logic [WIDTH-1:0]     MplierIn,
  output logic                 K,
  output logic                 M,
  output logic [2*WIDTH-1:0]   Prod
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_low;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (Load) begin
      mcand_d = McandIn;
      acc_d   = {1'b0, {WIDTH{1'b0}}, MplierIn};
      cnt_d   = CNT_W'(WIDTH - 1);
    end else if (Ad) begin
      // Upper half plus multiplicand; the carry lands in the extra top bit.
      acc_d[2*WIDTH:WIDTH] = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end else if (Sh) begin
      acc_d = acc_q >> 1;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_low = acc_q[2*WIDTH-1:0];
  assign K       = (cnt_q == '0);
  assign M       = acc_q[0];
  assign Prod    = Neg ? (~acc_low + (2*WIDTH)'(1)) : acc_low;

endmodule

// File: rtl/mul_hilo_unit.sv
// MULT/MULTU sequencer owning the architectural HI/LO registers; stalls
// HI/LO moves while a product is in flight.
module mul_hilo_unit
  import mul_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             MfRead,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] WrData,
  output logic             Ready,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic               sgn_q, sgn_d, neg_q, neg_d, done_q, done_d;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               load, ad, sh, k, m;
  logic [2*WIDTH-1:0] prod;

  // Magnitudes; the signed minimum maps onto itself as an unsigned value.
  assign a_mag = (sgn_q & opa_q[WIDTH-1]) ? (~opa_q + WIDTH'(1)) : opa_q;
  assign b_mag = (sgn_q & opb_q[WIDTH-1]) ? (~opb_q + WIDTH'(1)) : opb_q;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    load    = 1'b0;
    ad      = 1'b0;
    sh      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MtHi) hi_d = WrData;
        if (MtLo) lo_d = WrData;
        if (Start) begin
          sgn_d   = Signed;
          opa_d   = OpA;
          opb_d   = OpB;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        load    = 1'b1;
        neg_d   = sgn_q & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
        state_d = ST_ADD;
      end
      ST_ADD: begin
        ad      = m;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sh      = 1'b1;
        state_d = k ? ST_FIX : ST_ADD;
      end
      ST_FIX: begin
        {hi_d, lo_d} = prod;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (load),
    .Ad       (ad),
    .Sh       (sh),
    .Neg      (neg_q),
    .McandIn  (a_mag),
    .MplierIn (b_mag),
    .K        (k),
    .M        (m),
    .Prod     (prod)
  );

  assign Ready = (state_q == ST_IDLE);
  assign Busy  = ~Ready;
  assign Stall = (MfRead | MtHi | MtLo) & Busy;
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit: products, latency, stalls, HI/LO moves
// and reset behaviour.
module tb_mul_hilo_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start, Signed, MfRead, MtHi, MtLo;
  logic [31:0] OpA, OpB, WrData;
  logic        Ready, Busy, Stall, Done;
  logic [31:0] Hi, Lo;

  int ncmp  = 0;
  int nfail = 0;

  mul_hilo_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed),
    .OpA(OpA), .OpB(OpB), .MfRead(MfRead), .MtHi(MtHi), .MtLo(MtLo),
    .WrData(WrData), .Ready(Ready), .Busy(Busy), .Stall(Stall),
    .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one multiply from IDLE and checks latency, Busy window and result.
  task automatic do_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int bad_busy = 0;
    int bad_done = 0;
    Signed = sgn; OpA = a; OpB = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      if (Busy !== 1'b1 || Ready !== 1'b0) bad_busy++;
      if (Done !== 1'b0) bad_done++;
      tick();
    end
    chk({tag, "_busy_window"}, 64'(bad_busy), 64'd0);
    chk({tag, "_early_done"}, 64'(bad_done), 64'd0);
    chk({tag, "_done_c67"}, 64'(Done), 64'd1);
    chk({tag, "_ready_c67"}, 64'(Ready), 64'd1);
    chk({tag, "_hilo"}, {Hi, Lo}, exp);
    tick();
    chk({tag, "_done_c68"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int bad;
    Reset = 1'b1; Start = 1'b0; Signed = 1'b0; MfRead = 1'b1;
    MtHi = 1'b0; MtLo = 1'b0; OpA = '0; OpB = '0; WrData = '0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("rst_ready", 64'(Ready), 64'd1);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    MfRead = 1'b0;
    tick();

    do_mul(1'b0, 32'd7, 32'd6, 64'h00000000_0000002A, "multu_7x6");
    do_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max");
    do_mul(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "mult_m1xm1");
    do_mul(1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, "mult_m3x5");
    do_mul(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_min");

    // Moves in IDLE
    MtHi = 1'b1; WrData = 32'h1234;
    tick();
    MtHi = 1'b0;
    chk("mthi_hi", 64'(Hi), 64'h1234);
    chk("mthi_lo_kept", 64'(Lo), 64'h0);
    MtLo = 1'b1; WrData = 32'h5678;
    tick();
    MtLo = 1'b0;
    chk("mtlo_lo", 64'(Lo), 64'h5678);

    // Start with MTHI in the same cycle, then MTLO while busy
    Signed = 1'b0; OpA = 32'd7; OpB = 32'd6; Start = 1'b1;
    MtHi = 1'b1; WrData = 32'hABCD;
    tick();
    Start = 1'b0; MtHi = 1'b0;
    chk("start_mthi_hi", 64'(Hi), 64'hABCD);
    for (int c = 1; c < 5; c++) tick();
    MtLo = 1'b1; WrData = 32'hDEAD;
    #1;
    chk("mtlo_busy_stall", 64'(Stall), 64'd1);
    tick();
    MtLo = 1'b0;
    chk("mtlo_busy_lo_kept", 64'(Lo), 64'h5678);
    for (int c = 6; c <= 66; c++) tick();
    chk("start_mthi_done", 64'(Done), 64'd1);
    chk("start_mthi_prod", {Hi, Lo}, 64'h00000000_0000002A);
    tick();

    // MfRead with Start in IDLE, then held from cycle 10; ignored Start at 30
    Signed = 1'b1; OpA = 32'hFFFFFFFD; OpB = 32'd5; Start = 1'b1; MfRead = 1'b1;
    #1;
    chk("mf_start_stall", 64'(Stall), 64'd0);
    tick();
    Start = 1'b0; MfRead = 1'b0;
    bad = 0;
    for (int c = 1; c <= 66; c++) begin
      if (c >= 10) MfRead = 1'b1;
      Start = (c == 30);
      if (c == 30) begin Signed = 1'b0; OpA = 32'd9; OpB = 32'd9; end
      #1;
      if (Stall !== (c >= 10)) bad++;
      tick();
    end
    Start = 1'b0;
    chk("mf_stall_window", 64'(bad), 64'd0);
    chk("mf_stall_c67", 64'(Stall), 64'd0);
    chk("mf_done_c67", 64'(Done), 64'd1);
    chk("mf_prod", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF1);
    MfRead = 1'b0;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (Done !== 1'b0 || Ready !== 1'b1) bad++;
    end
    chk("ignored_start", 64'(bad), 64'd0);

    // Reset in the middle of a multiply
    Signed = 1'b0; OpA = 32'hFFFFFFFF; OpB = 32'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_ready", 64'(Ready), 64'd1);
    chk("midrst_hilo", {Hi, Lo}, 64'd0);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (Done !== 1'b0) bad++;
      tick();
    end
    chk("midrst_no_done", 64'(bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
